// File: rtl/rv32i_types.sv
// Shared types for the branch-resolution back end: per-entry prediction metadata,
// resolver FSM states and the next-PC helper used by both predicted and actual paths.
package rv32i_types;

  localparam int SIZE_GLOBAL      = 8;
  localparam int DEPTH_BR_RESOLVE = 8;

  typedef struct packed {
    logic [31:0]            pc;
    logic                   pred_taken;
    logic [31:0]            pred_target;
    logic [SIZE_GLOBAL-1:0] hist;
  } br_meta_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } br_state_t;

  function automatic logic [31:0] next_pc(input logic taken, input logic [31:0] target,
                                          input logic [31:0] pc);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/br_resolver_if.sv
// Fetch push, execute resolve and predictor update bundle around br_resolver.
// slave is the resolver side; master is the fetch/execute/predictor side.
interface br_resolver_if
  import rv32i_types::*;
#(
  parameter int DEPTH  = DEPTH_BR_RESOLVE,
  parameter int HIST_W = SIZE_GLOBAL
);
  logic                     push_valid;
  logic [31:0]              push_pc;
  logic                     push_pred_taken;
  logic [31:0]              push_pred_target;
  logic [HIST_W-1:0]        push_hist;
  logic                     push_ready;
  logic                     res_valid;
  logic [31:0]              res_pc;
  logic                     res_is_br;
  logic                     res_taken;
  logic [31:0]              res_target;
  logic                     updating;
  logic                     br_op;
  logic [31:0]              update_pc;
  logic                     br_en;
  logic [HIST_W-1:0]        br_history_old;
  logic                     pred_correct;
  logic                     flush;
  logic [31:0]              redirect_pc;
  logic                     order_err;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  push_valid, push_pc, push_pred_taken, push_pred_target, push_hist,
    input  res_valid, res_pc, res_is_br, res_taken, res_target,
    output push_ready, updating, br_op, update_pc, br_en, br_history_old,
    output pred_correct, flush, redirect_pc, order_err, count
  );

  modport master (
    output push_valid, push_pc, push_pred_taken, push_pred_target, push_hist,
    output res_valid, res_pc, res_is_br, res_taken, res_target,
    input  push_ready, updating, br_op, update_pc, br_en, br_history_old,
    input  pred_correct, flush, redirect_pc, order_err, count
  );
endinterface

// File: rtl/br_meta_fifo.sv
// Synchronous FIFO with single-cycle clear; the caller only pushes when not full
// and only pops when not empty. DEPTH must be a power of two so pointers wrap freely.
module br_meta_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 73
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;

  // NOTE: the storage array has no reset; occupancy and pointers decide which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
endmodule

// File: rtl/br_resolver.sv
// Holds prediction metadata for in-flight control-flow instructions, checks each
// resolve against the oldest entry, trains the predictor and raises flush/redirect.
module br_resolver
  import rv32i_types::*;
#(
  parameter int DEPTH  = DEPTH_BR_RESOLVE,
  parameter int HIST_W = SIZE_GLOBAL
) (
  input  logic           clk,
  input  logic           rst,
  br_resolver_if.slave   io
);
  localparam int CW = $clog2(DEPTH) + 1;

  br_state_t         state_q, state_d;
  br_meta_t          wmeta, head;
  logic [HIST_W-1:0] head_hist;
  logic [CW-1:0]     count;
  logic              full, empty, fifo_push, fifo_pop, clear;
  logic              res_fire, err_c, ok_c, mispred_c;
  logic [31:0]       actual_next;

  always_comb begin
    wmeta.pc          = io.push_pc;
    wmeta.pred_taken  = io.push_pred_taken;
    wmeta.pred_target = io.push_pred_target;
    wmeta.hist        = io.push_hist;
  end

  br_meta_fifo #(.DEPTH(DEPTH), .WIDTH($bits(br_meta_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wmeta),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head_hist   = head.hist;
  assign actual_next = next_pc(io.res_taken, io.res_target, io.res_pc);
  assign io.count    = count;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    io.push_ready = 1'b0;
    res_fire      = 1'b0;
    err_c         = 1'b0;
    ok_c          = 1'b0;
    mispred_c     = 1'b0;
    clear         = 1'b0;
    fifo_pop      = 1'b0;
    fifo_push     = 1'b0;
    case (state_q)
      RUN: begin
        io.push_ready = !full;
        res_fire      = io.res_valid;
        err_c         = res_fire && (empty || (io.res_pc != head.pc));
        ok_c          = res_fire && !err_c && (io.res_taken == head.pred_taken) &&
                        (!io.res_taken || (io.res_target == head.pred_target));
        mispred_c     = res_fire && !ok_c;
        // A mispredict wipes the queue, including anything fetched this cycle.
        clear         = mispred_c;
        fifo_pop      = res_fire && !empty && !mispred_c;
        fifo_push     = io.push_valid && !full && !mispred_c;
        if (mispred_c) state_d = FLUSH;
      end
      FLUSH: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io.updating       <= 1'b0;
      io.br_op          <= 1'b0;
      io.update_pc      <= '0;
      io.br_en          <= 1'b0;
      io.br_history_old <= '0;
      io.pred_correct   <= 1'b0;
      io.flush          <= 1'b0;
      io.redirect_pc    <= '0;
      io.order_err      <= 1'b0;
    end else begin
      io.updating       <= res_fire && !err_c;
      io.br_op          <= res_fire && io.res_is_br;
      io.update_pc      <= res_fire ? io.res_pc : '0;
      io.br_en          <= res_fire && io.res_taken;
      io.br_history_old <= (res_fire && !err_c) ? head_hist : '0;
      io.pred_correct   <= ok_c;
      io.flush          <= mispred_c;
      io.redirect_pc    <= mispred_c ? actual_next : '0;
      io.order_err      <= err_c;
    end
  end
endmodule

// File: tb/tb_br_resolver.sv
// Directed bench for br_resolver: a reference queue predicts each resolve outcome,
// expected update packets are queued at drive time and compared one cycle later.
module tb_br_resolver;
  import rv32i_types::*;

  localparam int DEPTH = DEPTH_BR_RESOLVE;
  localparam int HW    = SIZE_GLOBAL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  br_resolver_if #(.DEPTH(DEPTH), .HIST_W(HW)) bif ();

  br_resolver #(.DEPTH(DEPTH), .HIST_W(HW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bif)
  );

  typedef struct {
    logic [31:0]   pc;
    logic          pt;
    logic [31:0]   tgt;
    logic [HW-1:0] hist;
  } ent_t;

  typedef struct {
    logic          updating;
    logic          br_op;
    logic [31:0]   update_pc;
    logic          br_en;
    logic [HW-1:0] hist;
    logic          pred_correct;
    logic          flush;
    logic [31:0]   redirect;
    logic          order_err;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  logic [31:0] last_redirect;
  logic        last_flush, last_ok, last_updating, last_order_err, last_br_en;
  logic [HW-1:0] last_hist;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.push_valid       = 1'b0;
    bif.push_pc          = '0;
    bif.push_pred_taken  = 1'b0;
    bif.push_pred_target = '0;
    bif.push_hist        = '0;
    bif.res_valid        = 1'b0;
    bif.res_pc           = '0;
    bif.res_is_br        = 1'b0;
    bif.res_taken        = 1'b0;
    bif.res_target       = '0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_push_ready"}, 32'(bif.push_ready), 32'd1);
    check({pfx, "_count"},      32'(bif.count), 32'd0);
    check({pfx, "_updating"},   32'(bif.updating), 32'd0);
    check({pfx, "_br_op"},      32'(bif.br_op), 32'd0);
    check({pfx, "_update_pc"},  bif.update_pc, 32'd0);
    check({pfx, "_br_en"},      32'(bif.br_en), 32'd0);
    check({pfx, "_hist"},       32'(bif.br_history_old), 32'd0);
    check({pfx, "_pred_ok"},    32'(bif.pred_correct), 32'd0);
    check({pfx, "_flush"},      32'(bif.flush), 32'd0);
    check({pfx, "_redirect"},   bif.redirect_pc, 32'd0);
    check({pfx, "_order_err"},  32'(bif.order_err), 32'd0);
  endtask

  task automatic compare_out();
    exp_t x;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    check("updating",     32'(bif.updating), 32'(x.updating));
    check("br_op",        32'(bif.br_op), 32'(x.br_op));
    check("update_pc",    bif.update_pc, x.update_pc);
    check("br_en",        32'(bif.br_en), 32'(x.br_en));
    check("hist",         32'(bif.br_history_old), 32'(x.hist));
    check("pred_correct", 32'(bif.pred_correct), 32'(x.pred_correct));
    check("flush",        32'(bif.flush), 32'(x.flush));
    check("redirect_pc",  bif.redirect_pc, x.redirect);
    check("order_err",    32'(bif.order_err), 32'(x.order_err));
    last_redirect  = bif.redirect_pc;
    last_flush     = bif.flush;
    last_ok        = bif.pred_correct;
    last_updating  = bif.updating;
    last_order_err = bif.order_err;
    last_br_en     = bif.br_en;
    last_hist      = bif.br_history_old;
  endtask

  // One RUN-state cycle with optional push and resolve; a mispredict also spends the FLUSH cycle.
  task automatic cycle(input logic pv, input logic [31:0] ppc, input logic pt,
                       input logic [31:0] ptgt, input logic [HW-1:0] ph,
                       input logic rv, input logic [31:0] rpc, input logic rbr,
                       input logic rt, input logic [31:0] rtgt);
    ent_t e;
    exp_t x;
    logic oerr, ok, mis, accept;
    e = '{pc: '0, pt: 1'b0, tgt: '0, hist: '0};
    if (mq.size() != 0) e = mq[0];
    oerr   = (mq.size() == 0) || (rpc != e.pc);
    ok     = !oerr && (rt == e.pt) && (!rt || (rtgt == e.tgt));
    mis    = rv && !ok;
    accept = pv && (mq.size() < DEPTH) && !mis;
    check("push_ready", 32'(bif.push_ready), 32'(mq.size() < DEPTH));

    bif.push_valid = pv; bif.push_pc = ppc; bif.push_pred_taken = pt;
    bif.push_pred_target = ptgt; bif.push_hist = ph;
    bif.res_valid = rv; bif.res_pc = rpc; bif.res_is_br = rbr;
    bif.res_taken = rt; bif.res_target = rtgt;
    if (rv) begin
      x.updating     = !oerr;
      x.br_op        = rbr;
      x.update_pc    = rpc;
      x.br_en        = rt;
      x.hist         = oerr ? '0 : e.hist;
      x.pred_correct = ok;
      x.flush        = !ok;
      x.redirect     = !ok ? (rt ? rtgt : rpc + 32'd4) : 32'd0;
      x.order_err    = oerr;
      sb.push_back(x);
    end
    if (mis) mq.delete();
    else if (rv && mq.size() != 0) void'(mq.pop_front());
    if (accept) mq.push_back('{pc: ppc, pt: pt, tgt: ptgt, hist: ph});

    tick();
    idle_inputs();
    if (rv) compare_out();
    else begin
      check("quiet_updating", 32'(bif.updating), 32'd0);
      check("quiet_flush",    32'(bif.flush), 32'd0);
    end
    check("count", 32'(bif.count), 32'(mq.size()));
    if (mis) begin
      check("flush_push_ready", 32'(bif.push_ready), 32'd0);
      tick();
      check("post_flush_flush", 32'(bif.flush), 32'd0);
      check("post_flush_ready", 32'(bif.push_ready), 32'd1);
    end
  endtask

  task automatic push_only(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                           input logic [HW-1:0] h);
    cycle(1'b1, pc, pt, tgt, h, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic br, input logic t,
                         input logic [31:0] tgt);
    cycle(1'b0, 32'd0, 1'b0, 32'd0, '0, 1'b1, pc, br, t, tgt);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Correct taken branch trains the predictor without a flush.
    push_only(32'h100, 1'b1, 32'h140, 8'h05);
    resolve(32'h100, 1'b1, 1'b1, 32'h140);
    check("t1_pred_ok", 32'(last_ok), 32'd1);
    check("t1_br_en", 32'(last_br_en), 32'd1);
    check("t1_hist", 32'(last_hist), 32'h5);
    check("t1_flush", 32'(last_flush), 32'd0);
    resolve(32'h0, 1'b0, 1'b0, 32'h0);
    push_only(32'h0, 1'b0, 32'h0, '0);
    check("t1_no_pulse_repeat", 32'(bif.updating), 32'd0);
    resolve(32'h0, 1'b0, 1'b0, 32'h0);

    // Predicted not-taken, actually taken.
    push_only(32'h200, 1'b0, 32'h0, 8'h0a);
    resolve(32'h200, 1'b1, 1'b1, 32'h180);
    check("t2_redirect", last_redirect, 32'h180);
    check("t2_flush", 32'(last_flush), 32'd1);

    // Wrong target, then wrong direction.
    push_only(32'h300, 1'b1, 32'h340, 8'h33);
    resolve(32'h300, 1'b1, 1'b1, 32'h360);
    check("t3_redirect_tgt", last_redirect, 32'h360);
    push_only(32'h300, 1'b1, 32'h340, 8'h33);
    resolve(32'h300, 1'b1, 1'b0, 32'h0);
    check("t3_redirect_seq", last_redirect, 32'h304);

    // Fill, overflow attempt, push with pop at full, push with pop below full, drain.
    for (int i = 0; i < DEPTH; i++) push_only(32'h1000 + 32'(4 * i), 1'b0, 32'h0, HW'(i + 1));
    check("full_ready", 32'(bif.push_ready), 32'd0);
    push_only(32'hdead, 1'b1, 32'hbeef, 8'hff);
    check("full_count", 32'(bif.count), 32'(DEPTH));
    cycle(1'b1, 32'h2000, 1'b0, 32'h0, 8'h20, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h0);
    check("full_pop_count", 32'(bif.count), 32'(DEPTH - 1));
    push_only(32'h2004, 1'b0, 32'h0, 8'h21);
    resolve(32'h1004, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 32'h2008, 1'b1, 32'h2100, 8'h22, 1'b1, 32'h1008, 1'b1, 1'b0, 32'h0);
    check("push_pop_count", 32'(bif.count), 32'(DEPTH - 1));
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++)
      resolve(mq[0].pc, 1'(i), mq[0].pt, mq[0].tgt);

    // Ordering errors: empty queue, PC mismatch, push into empty with same-cycle resolve.
    resolve(32'h600, 1'b1, 1'b1, 32'h640);
    check("t5_empty_err", 32'(last_order_err), 32'd1);
    check("t5_empty_upd", 32'(last_updating), 32'd0);
    check("t5_empty_redir", last_redirect, 32'h640);
    push_only(32'h500, 1'b1, 32'h540, 8'h50);
    resolve(32'h504, 1'b1, 1'b1, 32'h540);
    check("t5_pc_err", 32'(last_order_err), 32'd1);
    check("t5_pc_flush", 32'(last_flush), 32'd1);
    cycle(1'b1, 32'h700, 1'b0, 32'h0, 8'h07, 1'b1, 32'h700, 1'b1, 1'b0, 32'h0);
    check("t5_same_cycle_err", 32'(last_order_err), 32'd1);

    // Reset with entries queued, then reset during a flush cycle.
    for (int i = 0; i < 3; i++) push_only(32'h800 + 32'(4 * i), 1'b0, 32'h0, HW'(i));
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    mq.delete();
    for (int i = 0; i < 3; i++) push_only(32'h900 + 32'(4 * i), 1'b0, 32'h0, HW'(i));
    bif.res_valid = 1'b1; bif.res_pc = 32'h900; bif.res_is_br = 1'b1;
    bif.res_taken = 1'b1; bif.res_target = 32'h980;
    tick();
    idle_inputs();
    check("rst_flush_seen", 32'(bif.flush), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_flush");
    rst = 1'b0;
    mq.delete();
    push_only(32'ha00, 1'b1, 32'ha80, 8'h0c);
    resolve(32'ha00, 1'b0, 1'b1, 32'ha80);
    check("after_rst_ok", 32'(last_ok), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
